// File: rtl/fd_exc_reg_pkg.sv
// Shared constants and types for the IF/ID register slice.
// Exception codes, cause field layout and the D-slot bundle.
package fd_exc_reg_pkg;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_RI   = 5'd10;

  localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_4ffc;

  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cause;
    logic        valid;
  } dSlot_t;

  function automatic logic [31:0] mkCause(
    input logic       bd,
    input logic [4:0] code
  );
    logic [31:0] c;
    c = '0;
    c[CAUSE_BD] = bd;
    c[CAUSE_EXC_HI:CAUSE_EXC_LO] = code;
    return c;
  endfunction

endpackage

// File: rtl/fd_exc_reg_if.sv
// F->D boundary bundle: IFU/hazard/CP0 controls in,
// latched decode-stage view out.
interface fd_exc_reg_if;

  logic        stall;
  logic        exc_flush;
  logic        eretD;
  logic        brD;
  logic [31:0] pcF;
  logic [31:0] instrF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc8D;
  logic [31:0] causeD;
  logic        validD;

  modport master (
    output stall, exc_flush, eretD, brD,
    output pcF, instrF,
    input  instrD, pcD, pc8D, causeD, validD
  );

  modport slave (
    input  stall, exc_flush, eretD, brD,
    input  pcF, instrF,
    output instrD, pcD, pc8D, causeD, validD
  );

endinterface

// File: rtl/fd_exc_reg_pc_range_chk.sv
// Legality check for an instruction/data address:
// word aligned and inside [LO, HI], unsigned.
module fd_exc_reg_pc_range_chk #(
  parameter logic [31:0] LO = 32'h0000_3000,
  parameter logic [31:0] HI = 32'h0000_4ffc
) (
  input  logic [31:0] addr,
  output logic        ok
);

  // Alignment and window test, purely combinational.
  always_comb begin
    ok = (addr[1:0] == 2'b00)
      && (addr >= LO)
      && (addr <= HI);
  end

endmodule

// File: rtl/fd_exc_reg.sv
// IF/ID pipeline register with fetch AdEL detection,
// delay-slot marking and bubble insertion.
module fd_exc_reg
  import fd_exc_reg_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input logic          clk,
  input logic          reset,
  fd_exc_reg_if.slave  bus
);

  logic   adrOk;
  dSlot_t slotQ;
  dSlot_t slotN;

  fd_exc_reg_pc_range_chk #(
    .LO (PC_RESET),
    .HI (PC_LIMIT)
  ) uChk (
    .addr (bus.pcF),
    .ok   (adrOk)
  );

  // Next slot: flush beats stall, stall beats eret.
  always_comb begin
    slotN = slotQ;
    priority case (1'b1)
      bus.exc_flush: begin
        slotN.instr = '0;
        slotN.pc    = bus.pcF;
        slotN.cause = '0;
        slotN.valid = 1'b0;
      end
      bus.stall: begin
        slotN = slotQ;
      end
      bus.eretD: begin
        slotN.instr = '0;
        slotN.pc    = bus.pcF;
        slotN.cause = '0;
        slotN.valid = 1'b0;
      end
      default: begin
        slotN.instr = adrOk ? bus.instrF : '0;
        slotN.pc    = bus.pcF;
        slotN.cause = mkCause(bus.brD,
                              adrOk ? EXC_NONE : EXC_ADEL);
        slotN.valid = 1'b1;
      end
    endcase
  end

  // Slot register with asynchronous reset to a nop at PC_RESET.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slotQ.instr <= '0;
      slotQ.pc    <= PC_RESET;
      slotQ.cause <= '0;
      slotQ.valid <= 1'b0;
    end else begin
      slotQ <= slotN;
    end
  end

  assign bus.instrD = slotQ.instr;
  assign bus.pcD    = slotQ.pc;
  assign bus.pc8D   = slotQ.pc + 32'd8;
  assign bus.causeD = slotQ.cause;
  assign bus.validD = slotQ.valid;

endmodule

// File: tb/tb_fd_exc_reg.sv
// Bench for fd_exc_reg: directed vector table, reset
// corner cases, then random traffic against a rule model.
module tb_fd_exc_reg;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fd_exc_reg_if bus ();

  fd_exc_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        eret;
    logic        br;
    logic [31:0] pcF;
    logic [31:0] instrF;
    logic [31:0] eInstr;
    logic [31:0] ePc;
    logic [31:0] eCause;
    logic        eValid;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  logic [31:0] mInstr;
  logic [31:0] mPc;
  logic [31:0] mCause;
  logic        mValid;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chkAll(input string nm,
                        input logic [31:0] ei,
                        input logic [31:0] ep,
                        input logic [31:0] ec,
                        input logic        ev);
    chk({nm, ".instrD"}, bus.instrD, ei);
    chk({nm, ".pcD"}, bus.pcD, ep);
    chk({nm, ".pc8D"}, bus.pc8D, ep + 32'd8);
    chk({nm, ".causeD"}, bus.causeD, ec);
    chk({nm, ".validD"}, {31'b0, bus.validD}, {31'b0, ev});
  endtask

  task automatic drive(input logic s, input logic f,
                       input logic e, input logic b,
                       input logic [31:0] p,
                       input logic [31:0] i);
    bus.stall     = s;
    bus.exc_flush = f;
    bus.eretD     = e;
    bus.brD       = b;
    bus.pcF       = p;
    bus.instrF    = i;
  endtask

  function automatic logic legal(input logic [31:0] p);
    return (p % 4 == 0) && p >= 32'h3000 && p <= 32'h4ffc;
  endfunction

  task automatic modelStep();
    if (bus.exc_flush || (!bus.stall && bus.eretD)) begin
      mInstr = 0;
      mPc    = bus.pcF;
      mCause = 0;
      mValid = 0;
    end else if (!bus.stall) begin
      mPc    = bus.pcF;
      mValid = 1;
      if (legal(bus.pcF)) begin
        mInstr = bus.instrF;
        mCause = bus.brD ? 32'h8000_0000 : 32'h0;
      end else begin
        mInstr = 0;
        mCause = bus.brD ? 32'h8000_0010 : 32'h10;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{0,0,0,0,32'h3000,32'h3c011234,
                 32'h3c011234,32'h3000,32'h0,1};
    vecs[1]  = '{0,0,0,0,32'h3002,32'h11111111,
                 32'h0,32'h3002,32'h10,1};
    vecs[2]  = '{0,0,0,0,32'h5000,32'h11111111,
                 32'h0,32'h5000,32'h10,1};
    vecs[3]  = '{0,0,0,0,32'h2ffc,32'h11111111,
                 32'h0,32'h2ffc,32'h10,1};
    vecs[4]  = '{0,0,0,0,32'h4ffc,32'h000000aa,
                 32'haa,32'h4ffc,32'h0,1};
    vecs[5]  = '{0,0,0,1,32'h3008,32'h00000022,
                 32'h22,32'h3008,32'h8000_0000,1};
    vecs[6]  = '{0,0,0,1,32'h3009,32'h00000022,
                 32'h0,32'h3009,32'h8000_0010,1};
    vecs[7]  = '{0,0,0,0,32'h3004,32'h00000033,
                 32'h33,32'h3004,32'h0,1};
    vecs[8]  = '{1,0,0,1,32'h3010,32'h00000044,
                 32'h33,32'h3004,32'h0,1};
    vecs[9]  = '{1,0,0,1,32'h3014,32'h00000044,
                 32'h33,32'h3004,32'h0,1};
    vecs[10] = '{1,0,0,0,32'h5018,32'h00000044,
                 32'h33,32'h3004,32'h0,1};
    vecs[11] = '{0,0,0,0,32'h301c,32'h00000055,
                 32'h55,32'h301c,32'h0,1};
    vecs[12] = '{1,1,0,1,32'h4180,32'h00000099,
                 32'h0,32'h4180,32'h0,0};
    vecs[13] = '{0,0,0,0,32'h3020,32'h00000066,
                 32'h66,32'h3020,32'h0,1};
    vecs[14] = '{0,0,1,1,32'h3024,32'h00000067,
                 32'h0,32'h3024,32'h0,0};
    vecs[15] = '{0,0,0,0,32'h3028,32'h00000077,
                 32'h77,32'h3028,32'h0,1};
    vecs[16] = '{1,0,1,0,32'h302c,32'h00000078,
                 32'h77,32'h3028,32'h0,1};
    vecs[17] = '{0,0,1,0,32'h3030,32'h00000079,
                 32'h0,32'h3030,32'h0,0};
    vecs[18] = '{0,1,0,1,32'h3035,32'h0000007a,
                 32'h0,32'h3035,32'h0,0};

    drive(0, 0, 0, 0, 32'h3000, 32'h0);
    reset = 1'b1;
    #12;
    chkAll("reset", 32'h0, 32'h3000, 32'h0, 1'b0);
    reset = 1'b0;
    #2;
    chkAll("resetRel", 32'h0, 32'h3000, 32'h0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].eret,
            vecs[i].br, vecs[i].pcF, vecs[i].instrF);
      @(posedge clk);
      #1;
      chkAll($sformatf("vec%0d", i), vecs[i].eInstr,
             vecs[i].ePc, vecs[i].eCause, vecs[i].eValid);
    end

    drive(0, 0, 0, 0, 32'h3040, 32'h12345678);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chkAll("asyncRst", 32'h0, 32'h3000, 32'h0, 1'b0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chkAll("postRst", 32'h12345678, 32'h3040, 32'h0, 1'b1);

    mInstr = 32'h12345678;
    mPc    = 32'h3040;
    mCause = 0;
    mValid = 1;
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] p;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)
        p = 32'h3000 + ($urandom_range(0, 32'h7ff) << 2);
      else if (sel < 9)
        p = $urandom_range(32'h2ff0, 32'h5010);
      else
        p = $urandom;
      drive($urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0,
            p, $urandom);
      modelStep();
      @(posedge clk);
      #1;
      chkAll($sformatf("rnd%0d", n), mInstr, mPc,
             mCause, mValid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
